// File: rtl/mem_bank_ctrl_if.sv
// mem_bank_ctrl_if
//   Bundles the pipeline request/response handshake and the unified-memory
//   bank bus of mem_bank_ctrl.
//   slave  : the controller (consumes requests, drives the bank bus)
//   master : the pipeline and memory side (issues requests, returns mem_rd)
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response: resp_valid, resp_ready, resp_rdata, resp_err
//   Memory  : mem_we[3:0], mem_a/mem_wd/mem_rd (4 lanes of WIDTH bits,
//             lane k at [WIDTH*(k+1)-1:WIDTH*k])
interface mem_bank_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [WIDTH-1:0]     req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WIDTH-1:0]     resp_rdata;
  logic                 resp_err;
  logic [3:0]           mem_we;
  logic [WIDTH*4-1:0]   mem_a;
  logic [WIDTH*4-1:0]   mem_wd;
  logic [WIDTH*4-1:0]   mem_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl
//   Routes single load/store requests from a pipeline to one of four banks
//   of a unified memory. Address bits [WIDTH-1:WIDTH-2] select the bank,
//   bits [WIDTH-3:0] are the word offset. Bank depths: 1024, 32, 1024, 512.
//   Bank 2 is 5 bits wide: stores truncate to [4:0], loads zero-extend.
//   One request per three cycles minimum: IDLE -> ACCESS -> RESP -> IDLE.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - mem_bank_ctrl_if.slave (request, response and bank bus)
//
//   Build option:
//     MEMCTRL_RANGECHK_EN defined   : offsets are checked against the bank
//                                     depth; out-of-range accesses write
//                                     nothing, load 0 and set resp_err.
//     MEMCTRL_RANGECHK_EN undefined : offsets wrap modulo the bank depth,
//                                     resp_err is always 0.
module mem_bank_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_bank_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int OFFW = WIDTH - 2;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        bank_q, bank_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [OFFW-1:0]   eff_off;
  logic              in_range;
  logic [WIDTH-1:0]  lane_wd;
  logic [WIDTH-1:0]  lane_rd;
  logic [3:0]        mem_we_d;
  logic [WIDTH*4-1:0] mem_a_d;
  logic [WIDTH*4-1:0] mem_wd_d;

  function automatic logic [OFFW-1:0] depth_of(input logic [1:0] b);
    case (b)
      2'd0:    return OFFW'(1024);
      2'd1:    return OFFW'(32);
      2'd2:    return OFFW'(1024);
      default: return OFFW'(512);
    endcase
  endfunction

  // Offset qualification for the registered request.
  always_comb begin
    eff_off  = off_q;
    in_range = 1'b1;
`ifdef MEMCTRL_RANGECHK_EN
    in_range = (off_q < depth_of(bank_q));
`else
    // Depths are powers of two, so depth-1 is the wrap mask.
    eff_off  = off_q & (depth_of(bank_q) - OFFW'(1));
`endif
  end

  // Lane data with the narrow bank-2 adaptation applied in both directions.
  always_comb begin
    lane_rd = bus.mem_rd[int'(bank_q)*WIDTH +: WIDTH];
    lane_wd = wdata_q;
    if (bank_q == 2'd2) begin
      lane_rd = WIDTH'(lane_rd[4:0]);
      lane_wd = WIDTH'(wdata_q[4:0]);
    end
  end

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      bank_q  <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      bank_q  <= bank_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state and bank bus decode; the bank bus is decoded from the
  // registered state only, so it is quiet everywhere except ACCESS.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    bank_d   = bank_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we_d = '0;
    mem_a_d  = '0;
    mem_wd_d = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          bank_d  = bus.req_addr[WIDTH-1:WIDTH-2];
          off_d   = bus.req_addr[WIDTH-3:0];
          wdata_d = bus.req_wdata;
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        mem_a_d[int'(bank_q)*WIDTH +: WIDTH]  = WIDTH'(eff_off);
        mem_wd_d[int'(bank_q)*WIDTH +: WIDTH] = lane_wd;
        if (we_q && in_range) begin
          mem_we_d[bank_q] = 1'b1;
        end
        rdata_d = (we_q || !in_range) ? '0 : lane_rd;
`ifdef MEMCTRL_RANGECHK_EN
        err_d   = !in_range;
`else
        err_d   = 1'b0;
`endif
        state_d = RESP;
      end

      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = mem_we_d;
  assign bus.mem_a      = mem_a_d;
  assign bus.mem_wd     = mem_wd_d;

endmodule
